vga_fb_arbiter: RTL and testbench

- Shares one single-port 12-bit framebuffer RAM between two requesters: the VGA pixel fetch path and a pixel writer (CPU or drawing engine).
- Display reads prefetch sequential pixels into an internal show-ahead FIFO.
- The FIFO feeds vga_data to the vga timing block on pixel pops.
- The writer gets leftover RAM cycles through a valid/ready handshake; display priority escalates when the FIFO runs low.

---
 rtl/vga_fb_arbiter.sv | 157 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: VGA prefetch into a show-ahead FIFO plus a valid/ready pixel writer.
// Define STATS_EN to add the saturating underflow_cnt and wr_stall_cnt outputs.
module vga_fb_arbiter #(
  parameter int FB_PIXELS  = 307200,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 4,
  parameter int HIGH_WM    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [11:0]       vga_data,
  output logic              underflow,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [11:0]       wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata
`ifdef STATS_EN
  ,
  output logic [15:0]       underflow_cnt,
  output logic [15:0]       wr_stall_cnt
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  LOW_L     = LVL_W'(LOW_WM);
  localparam logic [LVL_W-1:0]  HIGH_L    = LVL_W'(HIGH_WM);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  localparam logic [1:0] S_URGENT = 2'd0;
  localparam logic [1:0] S_NORMAL = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              inflight_q, inflight_d;
  logic              underflow_q, underflow_d;
  logic [11:0]       fifo_mem [FIFO_DEPTH];

  logic fifo_empty, space_ok, grant_wr, rd_issue, push, pop, uf_event;

  // space_ok counts the outstanding read so the FIFO can never overflow on its return
  always_comb begin
    fifo_empty = (level_q == '0);
    space_ok   = (level_q + LVL_W'(inflight_q)) < DEPTH_L;
    grant_wr   = !rst && (state_q == S_NORMAL) && (level_q >= LOW_L) && wr_valid;
    rd_issue   = !rst && !frame_start && (state_q != S_FLUSH) && !grant_wr && space_ok;
    push       = inflight_q && !frame_start;
    pop        = pix_pop && !fifo_empty && !frame_start;
    uf_event   = pix_pop && fifo_empty && !frame_start;
  end

  always_comb begin
    wr_ready  = grant_wr;
    mem_en    = grant_wr || rd_issue;
    mem_we    = grant_wr;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_wr) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (rd_issue) begin
      mem_addr  = fetch_addr_q;
    end
    vga_data  = (rst || fifo_empty) ? 12'h000 : fifo_mem[rd_ptr_q];
    underflow = underflow_q;
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fetch_addr_d = fetch_addr_q;
    inflight_d   = rd_issue;
    underflow_d  = underflow_q | uf_event;
    if (frame_start) begin
      // Frame restart overrides any pop or read return in the same cycle
      state_d      = S_FLUSH;
      level_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fetch_addr_d = '0;
      inflight_d   = 1'b0;
    end else begin
      case (state_q)
        S_URGENT: if (level_q >= HIGH_L) state_d = S_NORMAL;
        S_NORMAL: if (level_q < LOW_L)   state_d = S_URGENT;
        default:  state_d = S_URGENT;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (rd_issue)
        fetch_addr_d = (fetch_addr_q == LAST_ADDR) ? '0 : fetch_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_URGENT;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= inflight_d;
      underflow_q  <= underflow_d;
    end
  end

  // Pixel storage carries no reset; occupancy is tracked by level_q alone
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
  end

`ifdef STATS_EN
  logic [15:0] uf_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      uf_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (uf_event && (uf_cnt_q != 16'hFFFF))
        uf_cnt_q <= uf_cnt_q + 16'd1;
      if (wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign underflow_cnt = uf_cnt_q;
  assign wr_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a 1-cycle-latency RAM model (FB_PIXELS=24 to exercise wrap).
module tb_vga_fb_arbiter;
  localparam int FBP = 24;
  localparam int AW  = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, frame_start, pix_pop, wr_valid, load;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [11:0]   vga_data;
  logic          underflow, wr_ready, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_wdata, mem_rdata;
`ifdef STATS_EN
  logic [15:0]   underflow_cnt, wr_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_fetch, exp_pix;
  logic [11:0] ram [0:31];

  vga_fb_arbiter #(.FB_PIXELS(FBP), .ADDR_W(AW), .FIFO_DEPTH(16), .LOW_WM(4), .HIGH_WM(12)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_pop(pix_pop),
    .vga_data(vga_data), .underflow(underflow),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef STATS_EN
    , .underflow_cnt(underflow_cnt), .wr_stall_cnt(wr_stall_cnt)
`endif
  );

  // RAM content: ram[i] = 12'hA00 + i until the writer changes it
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) ram[i] <= 12'hA00 + 12'(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[4:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[4:0]];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; frame_start = 1'b0; pix_pop = 1'b0;
    wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 12'h0F0;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++; if ({wr_ready, mem_en} !== 2'b00) begin errors++; $display("FAIL reset_bus: got %b required 00", {wr_ready, mem_en}); end
      checks++; if (vga_data !== 12'h000) begin errors++; $display("FAIL reset_vga: got %h required 000", vga_data); end
      cyc();
    end
    rst = 1'b0; load = 1'b0; wr_valid = 1'b0;
    #2;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b required 0", underflow); end
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(0)}) begin errors++; $display("FAIL reset_first_read: got en=%b we=%b addr=%0d required 1 0 0", mem_en, mem_we, mem_addr); end
    cyc();
    #2;
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(1)}) begin errors++; $display("FAIL reset_second_read: got en=%b we=%b addr=%0d required 1 0 1", mem_en, mem_we, mem_addr); end
    cyc();
  endtask

  task automatic test_startup_fill();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      #2;
      if (c <= 3) begin
        checks++; if (vga_data !== 12'h000) begin errors++; $display("FAIL fill_vga_c%0d: got %h required 000", c, vga_data); end
      end else begin
        checks++; if (vga_data !== 12'hA00) begin errors++; $display("FAIL fill_vga_c%0d: got %h required a00", c, vga_data); end
      end
      if (c >= 2 && c <= 17) begin
        checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(c - 2)}) begin errors++; $display("FAIL fill_read_c%0d: got en=%b we=%b addr=%0d required 1 0 %0d", c, mem_en, mem_we, mem_addr, c - 2); end
      end else begin
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL fill_idle_c%0d: got mem_en=%b required 0", c, mem_en); end
      end
      cyc();
    end
    exp_fetch = 16;
    exp_pix   = 0;
  endtask

  task automatic test_wrap();
    int rd_cnt = 0;
    pix_pop = 1'b1;
    for (int c = 0; c < 44; c++) begin
      #2;
      checks++; if (vga_data !== 12'hA00 + 12'(exp_pix)) begin errors++; $display("FAIL wrap_pixel_%0d: got %h required %h", c, vga_data, 12'hA00 + 12'(exp_pix)); end
      if (mem_en === 1'b1) begin
        checks++; if ({mem_we, mem_addr} !== {1'b0, AW'(exp_fetch)}) begin errors++; $display("FAIL wrap_addr_%0d: got we=%b addr=%0d required 0 %0d", c, mem_we, mem_addr, exp_fetch); end
        exp_fetch = (exp_fetch + 1) % FBP;
        rd_cnt++;
      end
      exp_pix = (exp_pix + 1) % FBP;
      cyc();
    end
    pix_pop = 1'b0;
    checks++; if (rd_cnt !== 43) begin errors++; $display("FAIL wrap_read_count: got %0d required 43", rd_cnt); end
  endtask

  task automatic test_arbitration();
    bit seen = 1'b0;
    logic          got_we = 1'b0;
    logic [AW-1:0] got_addr = '0;
    repeat (5) cyc();
    wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 12'hF00; pix_pop = 1'b1;
    for (int k = 0; k < 14; k++) begin
      #2;
      if (k <= 12) begin
        checks++; if ({wr_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, AW'(5), 12'hF00}) begin errors++; $display("FAIL arb_grant_k%0d: got rdy=%b en=%b we=%b addr=%0d wd=%h required 1 1 1 5 f00", k, wr_ready, mem_en, mem_we, mem_addr, mem_wdata); end
      end
      cyc();
    end
    pix_pop = 1'b0;
    for (int k = 14; k <= 22; k++) begin
      #2;
      checks++; if ({wr_ready, mem_en, mem_we} !== 3'b010) begin errors++; $display("FAIL arb_urgent_k%0d: got rdy=%b en=%b we=%b required 0 1 0", k, wr_ready, mem_en, mem_we); end
      cyc();
    end
    for (int t = 0; t < 10; t++) begin
      #2;
      if (!seen && wr_ready === 1'b1) begin seen = 1'b1; got_we = mem_we; got_addr = mem_addr; end
      cyc();
    end
    wr_valid = 1'b0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL arb_regrant: got no wr_ready within 10 cycles, required regrant"); end
    checks++; if ({got_we, got_addr} !== {1'b1, AW'(5)}) begin errors++; $display("FAIL arb_regrant_bus: got we=%b addr=%0d required 1 5", got_we, got_addr); end
  endtask

  task automatic test_underflow();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0; pix_pop = 1'b1;
    #2;
    checks++; if (vga_data !== 12'h000) begin errors++; $display("FAIL uf_vga: got %h required 000", vga_data); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_before: got %b required 0", underflow); end
    cyc();
    pix_pop = 1'b0;
    #2;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b required 1", underflow); end
`ifdef STATS_EN
    checks++; if (underflow_cnt !== 16'd1) begin errors++; $display("FAIL uf_cnt: got %0d required 1", underflow_cnt); end
`endif
    cyc();
    repeat (3) cyc();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky_%0d: got %b required 1", i, underflow); end
      cyc();
    end
  endtask

  task automatic test_restart();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    repeat (9) cyc();
    // FIFO holds mem[0..6] with the read of address 7 in flight
    frame_start = 1'b1;
    #2;
    checks++; if (vga_data !== 12'hA00) begin errors++; $display("FAIL rs_head_before: got %h required a00", vga_data); end
    cyc();
    frame_start = 1'b0;
    #2;
    checks++; if ({mem_en, vga_data} !== {1'b0, 12'h000}) begin errors++; $display("FAIL rs_flush: got en=%b vga=%h required 0 000", mem_en, vga_data); end
    cyc();
    #2;
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(0)}) begin errors++; $display("FAIL rs_read0: got en=%b we=%b addr=%0d required 1 0 0", mem_en, mem_we, mem_addr); end
    cyc();
    #2;
    checks++; if ({vga_data, mem_addr} !== {12'h000, AW'(1)}) begin errors++; $display("FAIL rs_read1: got vga=%h addr=%0d required 000 1", vga_data, mem_addr); end
    cyc();
    #2;
    checks++; if (vga_data !== 12'hA00) begin errors++; $display("FAIL rs_first_pixel: got %h required a00", vga_data); end
    cyc();
  endtask

  task automatic test_reset_mid_write();
    repeat (20) cyc();
    wr_valid = 1'b1; wr_addr = AW'(7); wr_data = 12'h0AB;
    #2;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rw_pre_grant: got %b required 1", wr_ready); end
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++; if ({wr_ready, mem_en, vga_data} !== {2'b00, 12'h000}) begin errors++; $display("FAIL rw_in_reset_%0d: got rdy=%b en=%b vga=%h required 0 0 000", i, wr_ready, mem_en, vga_data); end
      cyc();
    end
    rst = 1'b0; wr_valid = 1'b0;
    #2;
    checks++; if ({underflow, vga_data} !== {1'b0, 12'h000}) begin errors++; $display("FAIL rw_after: got uf=%b vga=%h required 0 000", underflow, vga_data); end
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(0)}) begin errors++; $display("FAIL rw_read0: got en=%b we=%b addr=%0d required 1 0 0", mem_en, mem_we, mem_addr); end
`ifdef STATS_EN
    checks++; if ({wr_stall_cnt, underflow_cnt} !== 32'd0) begin errors++; $display("FAIL rw_stats: got stall=%0d uf=%0d required 0 0", wr_stall_cnt, underflow_cnt); end
`endif
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_startup_fill();
    test_wrap();
    test_arbitration();
    test_underflow();
    test_restart();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
